// File: rtl/gpio_ser.sv
// gpio_ser -- LED / GPIO register block with a serial shifter that drives an
// external shift-register chain (clock, data, active-low clear, latch).
//
// Ports:
//   clk          single clock, all state changes on its rising edge
//   rst_n        asynchronous active-low reset
//   we           write strobe: loads counter_set, led_out, gpio_out from wdata
//   wdata[31:0]  [1:0] counter_set, [LED_W+1:2] LED, [LED_W+GPIO_W+1:LED_W+2] GPIO
//   start        request one serial transfer of the LED register
//   counter_set  registered counter-select field
//   led_out      LED register
//   gpio_out     GPIO register
//   ser_clk      shift clock to the external register (0 outside SHIFT)
//   ser_dout     shift data (0 outside SHIFT)
//   ser_clrn     active-low clear, low only in CLR
//   ser_pen      latch / output enable, low in CLR and SHIFT; its rise latches
//   busy         transfer in progress (CLR, SHIFT, LATCH)
//
// Build option: define GPIO_SER_AUTOREFRESH_EN to make any write that changes
// the LED field behave as a start request on the same edge.
//
// All outputs come straight from flops, so ser_clk cannot glitch on state
// decode; each output register is loaded from the *next* state/datapath.

module gpio_ser #(
  parameter int          LED_W    = 16,
  parameter int          GPIO_W   = 14,
  parameter logic [15:0] LED_INIT = 16'h2A2A,
  parameter int          DIV      = 1,
  parameter int          DIR      = 0,
  parameter int          INV      = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [31:0]       wdata,
  input  logic              start,
  output logic [1:0]        counter_set,
  output logic [LED_W-1:0]  led_out,
  output logic [GPIO_W-1:0] gpio_out,
  output logic              ser_clk,
  output logic              ser_dout,
  output logic              ser_clrn,
  output logic              ser_pen,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLR   = 2'd1,
    SHIFT = 2'd2,
    LATCH = 2'd3
  } state_t;

  localparam int DIV_CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int BIT_CW = $clog2(LED_W);
  localparam logic [DIV_CW-1:0] DIV_LAST = DIV_CW'(DIV - 1);
  localparam logic [BIT_CW-1:0] BIT_LAST = BIT_CW'(LED_W - 1);

  state_t state_reg, state_next;

  logic               pending_reg, pending_next;
  logic [1:0]         cs_reg, cs_next;
  logic [LED_W-1:0]   led_reg, led_next;
  logic [GPIO_W-1:0]  gpio_reg, gpio_next;
  logic [LED_W-1:0]   shift_reg, shift_next;
  logic [DIV_CW-1:0]  div_cnt_reg, div_cnt_next;
  logic               phase_reg, phase_next;
  logic [BIT_CW-1:0]  bit_cnt_reg, bit_cnt_next;

  logic busy_reg, busy_next;
  logic ser_clk_reg, ser_clk_next;
  logic ser_dout_reg, ser_dout_next;
  logic ser_clrn_reg, ser_clrn_next;
  logic ser_pen_reg, ser_pen_next;

  logic [LED_W-1:0]  wr_led;
  logic [GPIO_W-1:0] wr_gpio;
  logic              trig;
  logic              half_end;
  logic              bit_end;
  logic              last_bit;
  logic [LED_W-1:0]  led_ordered;
  logic [LED_W-1:0]  snapshot;

  assign wr_led  = wdata[LED_W+1:2];
  assign wr_gpio = wdata[LED_W+GPIO_W+1:LED_W+2];

  generate
    if (LED_W + GPIO_W + 2 < 32) begin : g_unused
      logic unused_wdata_hi;
      assign unused_wdata_hi = ^wdata[31:LED_W+GPIO_W+2];
    end
  endgenerate

`ifdef GPIO_SER_AUTOREFRESH_EN
  // A write that changes the LED field is treated exactly like start.
  assign trig = start | (we & (wr_led != led_reg));
`else
  assign trig = start;
`endif

  // The shifter always emits its MSB, so bit order is settled once at load
  // time by optionally reversing the LED register.
  genvar gi;
  generate
    for (gi = 0; gi < LED_W; gi++) begin : g_order
      if (DIR != 0) begin : g_lsb_first
        assign led_ordered[gi] = led_reg[LED_W-1-gi];
      end else begin : g_msb_first
        assign led_ordered[gi] = led_reg[gi];
      end
    end
  endgenerate

  assign snapshot = (INV != 0) ? ~led_ordered : led_ordered;

  assign half_end = (div_cnt_reg == DIV_LAST);
  assign bit_end  = half_end & phase_reg;
  assign last_bit = (bit_cnt_reg == BIT_LAST);

  // ---------------------------------------------------------------- state reg
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // --------------------------------------------------------------- next state
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (trig || pending_reg) state_next = CLR;
      CLR:     state_next = SHIFT;
      SHIFT:   if (bit_end && last_bit) state_next = LATCH;
      LATCH:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // ---------------------------------------------------------- datapath next
  always_comb begin
    cs_next      = we ? wdata[1:0] : cs_reg;
    led_next     = we ? wr_led     : led_reg;
    gpio_next    = we ? wr_gpio    : gpio_reg;

    // Requests during a transfer coalesce into one flag; entering CLR
    // consumes it.
    pending_next = pending_reg;
    if (state_reg == IDLE) begin
      if (state_next == CLR) pending_next = 1'b0;
    end else if (trig) begin
      pending_next = 1'b1;
    end

    shift_next   = shift_reg;
    div_cnt_next = div_cnt_reg;
    phase_next   = phase_reg;
    bit_cnt_next = bit_cnt_reg;
    case (state_reg)
      CLR: begin
        // Snapshot uses the register value, so a write on the start edge is
        // included while writes from here on are not.
        shift_next   = snapshot;
        div_cnt_next = '0;
        phase_next   = 1'b0;
        bit_cnt_next = '0;
      end
      SHIFT: begin
        if (half_end) begin
          div_cnt_next = '0;
          phase_next   = ~phase_reg;
          if (phase_reg) begin
            shift_next   = shift_reg << 1;
            bit_cnt_next = bit_cnt_reg + 1'b1;
          end
        end else begin
          div_cnt_next = div_cnt_reg + 1'b1;
        end
      end
      default: ;
    endcase
  end

  // ------------------------------------------------------------ outputs next
  always_comb begin
    busy_next     = (state_next != IDLE);
    ser_clrn_next = (state_next != CLR);
    ser_pen_next  = !((state_next == CLR) || (state_next == SHIFT));
    ser_clk_next  = (state_next == SHIFT) && phase_next;
    ser_dout_next = (state_next == SHIFT) && shift_next[LED_W-1];
  end

  // ----------------------------------------------------- datapath/output regs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_reg  <= 1'b0;
      cs_reg       <= 2'b00;
      led_reg      <= LED_INIT[LED_W-1:0];
      gpio_reg     <= '0;
      shift_reg    <= '0;
      div_cnt_reg  <= '0;
      phase_reg    <= 1'b0;
      bit_cnt_reg  <= '0;
      busy_reg     <= 1'b0;
      ser_clk_reg  <= 1'b0;
      ser_dout_reg <= 1'b0;
      ser_clrn_reg <= 1'b1;
      ser_pen_reg  <= 1'b1;
    end else begin
      pending_reg  <= pending_next;
      cs_reg       <= cs_next;
      led_reg      <= led_next;
      gpio_reg     <= gpio_next;
      shift_reg    <= shift_next;
      div_cnt_reg  <= div_cnt_next;
      phase_reg    <= phase_next;
      bit_cnt_reg  <= bit_cnt_next;
      busy_reg     <= busy_next;
      ser_clk_reg  <= ser_clk_next;
      ser_dout_reg <= ser_dout_next;
      ser_clrn_reg <= ser_clrn_next;
      ser_pen_reg  <= ser_pen_next;
    end
  end

  assign counter_set = cs_reg;
  assign led_out     = led_reg;
  assign gpio_out    = gpio_reg;
  assign busy        = busy_reg;
  assign ser_clk     = ser_clk_reg;
  assign ser_dout    = ser_dout_reg;
  assign ser_clrn    = ser_clrn_reg;
  assign ser_pen     = ser_pen_reg;

endmodule

// File: tb/tb_gpio_ser.sv
// tb_gpio_ser -- scoreboard bench for gpio_ser. Two instances: ch0 with the
// default parameters, ch1 with LED_W=8, GPIO_W=6, DIV=2, LSB first, no
// inversion. Stimulus pushes the expected serial word per transfer; a monitor
// rebuilds each word from ser_clk rises and pops/compares on each ser_pen rise.

module tb_gpio_ser;

  logic clk;
  logic rst_n;

  logic        we0, start0, we1, start1;
  logic [31:0] wdata0, wdata1;

  logic [1:0]  cs0, cs1;
  logic [15:0] led_out0;
  logic [7:0]  led_out1;
  logic [13:0] gpio0;
  logic [5:0]  gpio1;
  logic        sclk0, dout0, clrn0, pen0, busy0;
  logic        sclk1, dout1, clrn1, pen1, busy1;

  gpio_ser u_dut0 (
    .clk(clk), .rst_n(rst_n), .we(we0), .wdata(wdata0), .start(start0),
    .counter_set(cs0), .led_out(led_out0), .gpio_out(gpio0),
    .ser_clk(sclk0), .ser_dout(dout0), .ser_clrn(clrn0), .ser_pen(pen0),
    .busy(busy0)
  );

  gpio_ser #(
    .LED_W(8), .GPIO_W(6), .LED_INIT(16'h12A5), .DIV(2), .DIR(1), .INV(0)
  ) u_dut1 (
    .clk(clk), .rst_n(rst_n), .we(we1), .wdata(wdata1), .start(start1),
    .counter_set(cs1), .led_out(led_out1), .gpio_out(gpio1),
    .ser_clk(sclk1), .ser_dout(dout1), .ser_clrn(clrn1), .ser_pen(pen1),
    .busy(busy1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  logic [15:0] q0[$];
  logic [15:0] q1[$];

  logic [15:0] m_led [2];
  logic [15:0] m_gpio[2];
  logic [1:0]  m_cs  [2];

  task automatic chk(input string name, input int c, input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL ch%0d %s: got %0h expected %0h", c, name, got, exp);
    end
  endtask

  function automatic int w_of(input int c);
    return (c == 0) ? 16 : 8;
  endfunction

  function automatic int div_of(input int c);
    return (c == 0) ? 1 : 2;
  endfunction

  // Bits in wire order: ch0 MSB first and inverted, ch1 LSB first as-is.
  function automatic logic [15:0] exp_stream(input int c, input logic [15:0] led);
    logic [15:0] s;
    int w;
    int idx;
    s = '0;
    w = w_of(c);
    for (int i = 0; i < w; i++) begin
      idx = (c == 0) ? (w - 1 - i) : i;
      s = {s[14:0], (c == 0) ? ~led[idx] : led[idx]};
    end
    return s;
  endfunction

  task automatic push_exp(input int c, input logic [15:0] led);
    if (c == 0) q0.push_back(exp_stream(0, led));
    else        q1.push_back(exp_stream(1, led));
  endtask

  // ------------------------------------------------------------- monitor
  logic [15:0] word     [2];
  int          nbits    [2];
  int          busy_cnt [2];
  int          clrn_cnt [2];
  int          hi_run   [2];
  logic        prev_clk [2];
  logic        prev_pen [2];
  logic        prev_busy[2];

  always @(negedge clk) begin
    for (int c = 0; c < 2; c++) begin
      logic s_busy, s_pen, s_clrn, s_clk, s_dout;
      logic [15:0] e;
      if (c == 0) {s_busy, s_pen, s_clrn, s_clk, s_dout} = {busy0, pen0, clrn0, sclk0, dout0};
      else        {s_busy, s_pen, s_clrn, s_clk, s_dout} = {busy1, pen1, clrn1, sclk1, dout1};
      if (!rst_n) begin
        word[c] = '0; nbits[c] = 0; busy_cnt[c] = 0; clrn_cnt[c] = 0; hi_run[c] = 0;
        prev_clk[c] = 1'b0; prev_pen[c] = 1'b1; prev_busy[c] = 1'b0;
      end else begin
        if (s_pen && (s_clk || s_dout)) begin
          n_err++;
          $display("FAIL ch%0d idle_serial_lines: clk=%b dout=%b required 0", c, s_clk, s_dout);
        end
        if (s_clk && !prev_clk[c]) begin
          word[c] = {word[c][14:0], s_dout};
          nbits[c]++;
        end
        if (s_clk) hi_run[c]++;
        else if (prev_clk[c]) begin
          chk("ser_clk_high_len", c, hi_run[c], div_of(c));
          hi_run[c] = 0;
        end
        if (!s_clrn) clrn_cnt[c]++;
        if (s_busy) busy_cnt[c]++;
        else if (prev_busy[c]) begin
          chk("busy_len", c, busy_cnt[c], 2 + 2 * div_of(c) * w_of(c));
          busy_cnt[c] = 0;
        end
        if (s_pen && !prev_pen[c]) begin
          chk("bit_count", c, nbits[c], w_of(c));
          chk("clrn_low_cycles", c, clrn_cnt[c], 1);
          if ((c == 0 && q0.size() == 0) || (c == 1 && q1.size() == 0)) begin
            n_vec++; n_err++;
            $display("FAIL ch%0d unexpected_transfer: got word %0h expected none", c, word[c]);
          end else begin
            e = (c == 0) ? q0.pop_front() : q1.pop_front();
            chk("stream", c, word[c], e);
          end
          $display("ch%0d transfer word=%h bits=%0d", c, word[c], nbits[c]);
          word[c] = '0; nbits[c] = 0; clrn_cnt[c] = 0;
        end
        prev_clk[c] = s_clk; prev_pen[c] = s_pen; prev_busy[c] = s_busy;
      end
    end
  end

  // ------------------------------------------------------------- stimulus
  task automatic wr(input int c, input logic [1:0] cs, input logic [15:0] led,
                    input logic [15:0] gpio, input logic st, output logic auto_trig);
    @(negedge clk);
    auto_trig = 1'b0;
    if (c == 0) begin
`ifdef GPIO_SER_AUTOREFRESH_EN
      auto_trig = (led != m_led[0]);
`endif
      we0 = 1'b1; start0 = st; wdata0 = {gpio[13:0], led, cs};
      m_led[0] = led; m_gpio[0] = {2'b00, gpio[13:0]};
    end else begin
`ifdef GPIO_SER_AUTOREFRESH_EN
      auto_trig = (led[7:0] != m_led[1][7:0]);
`endif
      we1 = 1'b1; start1 = st; wdata1 = {16'hDEAD, gpio[5:0], led[7:0], cs};
      m_led[1] = {8'h00, led[7:0]}; m_gpio[1] = {10'h000, gpio[5:0]};
    end
    m_cs[c] = cs;
    $display("ch%0d write cs=%0d led=%h gpio=%h start=%b", c, cs, m_led[c], m_gpio[c], st);
    @(negedge clk);
    we0 = 1'b0; start0 = 1'b0; we1 = 1'b0; start1 = 1'b0;
    if (c == 0) begin
      chk("led_out", 0, led_out0, m_led[0]);
      chk("gpio_out", 0, gpio0, m_gpio[0]);
      chk("counter_set", 0, cs0, m_cs[0]);
    end else begin
      chk("led_out", 1, led_out1, m_led[1]);
      chk("gpio_out", 1, gpio1, m_gpio[1]);
      chk("counter_set", 1, cs1, m_cs[1]);
    end
  endtask

  task automatic start_pulse(input int c);
    @(negedge clk);
    if (c == 0) start0 = 1'b1; else start1 = 1'b1;
    @(negedge clk);
    start0 = 1'b0; start1 = 1'b0;
  endtask

  task automatic wait_done(input int c);
    int t;
    t = 0;
    while (((c == 0) ? (q0.size() != 0 || busy0) : (q1.size() != 0 || busy1)) && t < 2000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 2000) begin
      n_vec++; n_err++;
      $display("FAIL ch%0d transfer_timeout: got %0d pending words expected 0", c,
               (c == 0) ? q0.size() : q1.size());
      if (c == 0) q0.delete(); else q1.delete();
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic quiet(input int c, input int n);
    int hits;
    hits = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if ((c == 0) ? (busy0 || !pen0) : (busy1 || !pen1)) hits++;
    end
    chk("no_spurious_transfer", c, hits, 0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic a;
    logic [15:0] led, gpio;
    logic [1:0] cs;
    int t, cnt, falls;
    logic pp;

    rst_n = 1'b0;
    we0 = 0; start0 = 0; wdata0 = '0; we1 = 0; start1 = 0; wdata1 = '0;
    m_led[0] = 16'h2A2A; m_led[1] = 16'h00A5;
    m_gpio[0] = '0; m_gpio[1] = '0; m_cs[0] = '0; m_cs[1] = '0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_led_out", 0, led_out0, 16'h2A2A);
    chk("rst_led_out", 1, led_out1, 16'h00A5);
    chk("rst_gpio_out", 0, gpio0, 0);
    chk("rst_counter_set", 0, cs0, 0);
    chk("rst_lines", 0, {busy0, pen0, clrn0, sclk0, dout0}, 5'b01100);
    chk("rst_lines", 1, {busy1, pen1, clrn1, sclk1, dout1}, 5'b01100);
    rst_n = 1'b1;

    // 100 quiet cycles after release, no ser_clk activity
    cnt = 0; pp = sclk0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (sclk0 != pp || busy0 || !pen0 || !clrn0) cnt++;
      pp = sclk0;
    end
    chk("post_reset_quiet", 0, cnt, 0);
    chk("post_reset_led", 0, led_out0, 16'h2A2A);

    // 0x00FF MSB first inverted -> eight 1s then eight 0s
    wr(0, 2'd0, 16'h00FF, 16'h0000, 1'b1, a);
    push_exp(0, 16'h00FF);
    chk("busy_after_start", 0, busy0, 1);
    wait_done(0);

    // Randomised transfers on both channels
    for (int k = 0; k < 8; k++) begin
      led = 16'($urandom); gpio = 16'($urandom); cs = 2'($urandom);
      if ($urandom_range(0, 1) == 0) begin
        wr(0, cs, led, gpio, 1'b1, a);
        push_exp(0, led);
      end else begin
        wr(0, cs, led, gpio, 1'b0, a);
        push_exp(0, led);
        if (a) push_exp(0, led);
        start_pulse(0);
      end
      wait_done(0);
    end
    for (int k = 0; k < 6; k++) begin
      led = 16'($urandom); gpio = 16'($urandom); cs = 2'($urandom);
      if ($urandom_range(0, 1) == 0) begin
        wr(1, cs, led, gpio, 1'b1, a);
        push_exp(1, {8'h00, led[7:0]});
      end else begin
        wr(1, cs, led, gpio, 1'b0, a);
        push_exp(1, {8'h00, led[7:0]});
        if (a) push_exp(1, {8'h00, led[7:0]});
        start_pulse(1);
      end
      wait_done(1);
    end

    // Write during SHIFT does not disturb the stream in flight
    wr(0, 2'd2, 16'hBEEF, 16'h0123, 1'b1, a);
    push_exp(0, 16'hBEEF);
    repeat (6) @(negedge clk);
    wr(0, 2'd1, 16'h1234, 16'h0456, 1'b0, a);
    if (a) push_exp(0, 16'h1234);
    wait_done(0);
    quiet(0, 40);

    // Three starts during one transfer -> one extra transfer after LATCH
    wr(0, 2'd3, 16'hC3A5, 16'h0F0F, 1'b1, a);
    push_exp(0, 16'hC3A5);
    push_exp(0, 16'hC3A5);
    repeat (3) @(negedge clk);
    for (int k = 0; k < 3; k++) start_pulse(0);
    t = 0; pp = pen0;
    while (t < 500) begin
      @(negedge clk); t++;
      if (pen0 && !pp) break;
      pp = pen0;
    end
    cnt = 0;
    while (clrn0 && cnt < 20) begin
      @(negedge clk); cnt++;
    end
    chk("pending_restart_gap", 0, cnt, 2);
    wait_done(0);
    quiet(0, 40);

    // start held high in IDLE -> back-to-back transfers
    push_exp(0, m_led[0]);
    push_exp(0, m_led[0]);
    @(negedge clk);
    start0 = 1'b1;
    falls = 0; t = 0; pp = 1'b1;
    while (falls < 2 && t < 500) begin
      @(negedge clk); t++;
      if (!clrn0 && pp) falls++;
      pp = clrn0;
    end
    start0 = 1'b0;
    chk("held_start_transfers", 0, falls, 2);
    wait_done(0);
    quiet(0, 40);

    // Asynchronous reset in the middle of the bit stream
    wr(0, 2'd1, 16'h5A0F, 16'h1111, 1'b1, a);
    push_exp(0, 16'h5A0F);
    cnt = 0; t = 0; pp = sclk0;
    while (cnt < 7 && t < 500) begin
      @(negedge clk); t++;
      if (sclk0 && !pp) cnt++;
      pp = sclk0;
    end
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_lines", 0, {busy0, pen0, clrn0, sclk0, dout0}, 5'b01100);
    chk("async_rst_led", 0, led_out0, 16'h2A2A);
    chk("async_rst_gpio", 0, gpio0, 0);
    chk("async_rst_cs", 0, cs0, 0);
    chk("async_rst_led", 1, led_out1, 16'h00A5);
    q0.delete();
    m_led[0] = 16'h2A2A; m_gpio[0] = '0; m_cs[0] = '0;
    m_led[1] = 16'h00A5; m_gpio[1] = '0; m_cs[1] = '0;
    cnt = 0;
    repeat (3) begin
      @(negedge clk);
      if (!pen0) cnt++;
    end
    chk("pen_held_in_reset", 0, cnt, 0);
    rst_n = 1'b1;
    quiet(0, 60);

`ifdef GPIO_SER_AUTOREFRESH_EN
    // Changed LED field starts a transfer; the identical write does not
    wr(0, 2'd0, 16'h0001, 16'h0000, 1'b0, a);
    push_exp(0, 16'h0001);
    chk("autorefresh_busy", 0, busy0, 1);
    wait_done(0);
    wr(0, 2'd0, 16'h0001, 16'h0000, 1'b0, a);
    quiet(0, 40);
`else
    // Writes alone never start a transfer
    wr(0, 2'd0, 16'h0001, 16'h0000, 1'b0, a);
    quiet(0, 40);
`endif

    chk("leftover_expected", 0, q0.size(), 0);
    chk("leftover_expected", 1, q1.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
